// File: rtl/reg_writeback_arbiter.sv
// reg_writeback_arbiter
//   Write-side front end of the register file. Merges single-cycle ALU
//   results (priority) and multi-cycle memory results (queued in a small
//   FIFO) onto the file's single registered write port. Writes to r0 are
//   dropped, FIFO starvation is bounded, and a hazard query lets decode
//   stall on registers that still have a queued load write.
//
// Ports
//   clk_i, rst_i                 clock (rising), async active-high reset
//   alu_valid_i/addr_i/data_i    ALU result offered this cycle
//   alu_stall_o                  ALU result not taken; source must hold it
//   mem_valid_i/addr_i/data_i    memory result offered (valid/ready)
//   mem_ready_o                  FIFO has room (from registered count)
//   chk_addr_i, chk_hazard_o     decode query: address pending in FIFO
//   count_o                      registered FIFO occupancy
//   RegWrite_o/RDaddr_o/RDdata_o register-file write port (registered)
module reg_writeback_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        alu_valid_i,
  input  logic [ADDR_W-1:0]           alu_addr_i,
  input  logic [DATA_W-1:0]           alu_data_i,
  output logic                        alu_stall_o,
  input  logic                        mem_valid_i,
  output logic                        mem_ready_o,
  input  logic [ADDR_W-1:0]           mem_addr_i,
  input  logic [DATA_W-1:0]           mem_data_i,
  input  logic [ADDR_W-1:0]           chk_addr_i,
  output logic                        chk_hazard_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o,
  output logic                        RegWrite_o,
  output logic [ADDR_W-1:0]           RDaddr_o,
  output logic [DATA_W-1:0]           RDdata_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ALU,
    SEL_MEM
  } sel_e;

  // FIFO storage (no reset needed; validity comes from pointers/count)
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [SW-1:0]     r_starve;

  logic              r_we;
  logic [ADDR_W-1:0] r_rdaddr;
  logic [DATA_W-1:0] r_rddata;

  sel_e              w_sel;
  logic              w_empty;
  logic              w_force;
  logic              w_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_alu_wr;
  logic              w_hazard;
  logic [PW-1:0]     w_idx;
  logic [PW-1:0]     w_off;

  // Source selection and handshakes
  always_comb begin
    w_empty  = (r_count == '0);
    w_force  = !w_empty && (r_starve >= STARVE_C);
    w_sel    = SEL_NONE;
    if (w_force) begin
      w_sel = SEL_MEM;
    end else if (alu_valid_i) begin
      w_sel = SEL_ALU;
    end else if (!w_empty) begin
      w_sel = SEL_MEM;
    end
    w_pop    = (w_sel == SEL_MEM);
    w_alu_wr = (alu_addr_i != '0);
    // Ready uses registered count only: a full FIFO refuses even while popping.
    w_ready  = !rst_i && (r_count < DEPTH_C);
    // r0 results complete the handshake but are never queued.
    w_push   = mem_valid_i && w_ready && (mem_addr_i != '0);
  end

  assign alu_stall_o = !rst_i && w_force && alu_valid_i;
  assign mem_ready_o = w_ready;
  assign count_o     = r_count;

  // Hazard: an entry is live if its distance from the read pointer is below
  // the registered count. Same-cycle push is excluded, same-cycle pop still
  // counts, because both are judged against state before the edge.
  always_comb begin
    w_hazard = 1'b0;
    w_idx    = '0;
    w_off    = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      w_idx = PW'(i);
      w_off = w_idx - r_rptr;
      if (({1'b0, w_off} < r_count) && (r_fifo_addr[w_idx] == chk_addr_i)) begin
        w_hazard = 1'b1;
      end
    end
    if (chk_addr_i == '0) begin
      w_hazard = 1'b0;
    end
  end

  assign chk_hazard_o = w_hazard;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= mem_addr_i;
      r_fifo_data[r_wptr] <= mem_data_i;
    end
  end

  // FIFO pointers, occupancy and starvation counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_empty || w_pop) begin
        r_starve <= '0;
      end else if ((w_sel == SEL_ALU) && (r_starve < STARVE_C)) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end

  // Registered write port; address/data hold when no write is issued
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we     <= 1'b0;
      r_rdaddr <= '0;
      r_rddata <= '0;
    end else begin
      case (w_sel)
        SEL_ALU: begin
          r_we <= w_alu_wr;
          if (w_alu_wr) begin
            r_rdaddr <= alu_addr_i;
            r_rddata <= alu_data_i;
          end
        end
        SEL_MEM: begin
          r_we     <= 1'b1;
          r_rdaddr <= r_fifo_addr[r_rptr];
          r_rddata <= r_fifo_data[r_rptr];
        end
        default: r_we <= 1'b0;
      endcase
    end
  end

  assign RegWrite_o = r_we;
  assign RDaddr_o   = r_rdaddr;
  assign RDdata_o   = r_rddata;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
module tb_reg_writeback_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alu_valid_i;
  logic [4:0]  alu_addr_i;
  logic [31:0] alu_data_i;
  logic        alu_stall_o;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic [4:0]  mem_addr_i;
  logic [31:0] mem_data_i;
  logic [4:0]  chk_addr_i;
  logic        chk_hazard_o;
  logic [2:0]  count_o;
  logic        RegWrite_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;

  int checks   = 0;
  int failures = 0;
  int row      = 0;

  reg_writeback_arbiter #(
    .DATA_W      (32),
    .ADDR_W      (5),
    .FIFO_DEPTH  (4),
    .STARVE_LIMIT(3)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .alu_valid_i (alu_valid_i),
    .alu_addr_i  (alu_addr_i),
    .alu_data_i  (alu_data_i),
    .alu_stall_o (alu_stall_o),
    .mem_valid_i (mem_valid_i),
    .mem_ready_o (mem_ready_o),
    .mem_addr_i  (mem_addr_i),
    .mem_data_i  (mem_data_i),
    .chk_addr_i  (chk_addr_i),
    .chk_hazard_o(chk_hazard_o),
    .count_o     (count_o),
    .RegWrite_o  (RegWrite_o),
    .RDaddr_o    (RDaddr_o),
    .RDdata_o    (RDdata_o)
  );

  always #5 clk_i = ~clk_i;

  // One cycle: inputs, expected combinational outputs during the cycle,
  // expected registered outputs after the following rising edge.
  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_a;
    logic [31:0] alu_d;
    logic        mem_v;
    logic [4:0]  mem_a;
    logic [31:0] mem_d;
    logic [4:0]  chk_a;
    logic        e_stall;
    logic        e_ready;
    logic        e_haz;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input int unsigned av, input int unsigned aa, input int unsigned ad,
    input int unsigned mv, input int unsigned ma, input int unsigned md,
    input int unsigned ca,
    input int unsigned es, input int unsigned er, input int unsigned eh,
    input int unsigned ew, input int unsigned ea, input int unsigned ed,
    input int unsigned ec);
    vec_t v;
    v.alu_v   = 1'(av);
    v.alu_a   = 5'(aa);
    v.alu_d   = ad;
    v.mem_v   = 1'(mv);
    v.mem_a   = 5'(ma);
    v.mem_d   = md;
    v.chk_a   = 5'(ca);
    v.e_stall = 1'(es);
    v.e_ready = 1'(er);
    v.e_haz   = 1'(eh);
    v.e_we    = 1'(ew);
    v.e_addr  = 5'(ea);
    v.e_data  = ed;
    v.e_cnt   = 3'(ec);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (row %0d, t=%0t): got %0h expected %0h", nm, row, $time, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid_i = 1'b0;
    alu_addr_i  = '0;
    alu_data_i  = '0;
    mem_valid_i = 1'b0;
    mem_addr_i  = '0;
    mem_data_i  = '0;
    chk_addr_i  = '0;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic run_vec(input vec_t v);
    alu_valid_i = v.alu_v;
    alu_addr_i  = v.alu_a;
    alu_data_i  = v.alu_d;
    mem_valid_i = v.mem_v;
    mem_addr_i  = v.mem_a;
    mem_data_i  = v.mem_d;
    chk_addr_i  = v.chk_a;
    #1;
    chk("alu_stall", 32'(alu_stall_o), 32'(v.e_stall));
    chk("mem_ready", 32'(mem_ready_o), 32'(v.e_ready));
    chk("hazard", 32'(chk_hazard_o), 32'(v.e_haz));
    @(posedge clk_i);
    #1;
    chk("RegWrite", 32'(RegWrite_o), 32'(v.e_we));
    if (v.e_we) begin
      chk("RDaddr", 32'(RDaddr_o), 32'(v.e_addr));
      chk("RDdata", RDdata_o, v.e_data);
    end
    chk("count", 32'(count_o), 32'(v.e_cnt));
    row++;
  endtask

  task automatic chk_reset_state();
    chk("rst_RegWrite", 32'(RegWrite_o), 32'd0);
    chk("rst_RDaddr", 32'(RDaddr_o), 32'd0);
    chk("rst_RDdata", RDdata_o, 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_ready", 32'(mem_ready_o), 32'd0);
    chk("rst_stall", 32'(alu_stall_o), 32'd0);
  endtask

  initial begin
    //       av aa  ad            mv ma md        chk st rd hz we ea ed           cnt
    // ALU only, r0 suppressed
    tbl.push_back(mk(1, 3, 'h11,       0, 0, 0,      0, 0, 1, 0, 1, 3, 'h11,       0));
    tbl.push_back(mk(1, 0, 'h22,       0, 0, 0,      0, 0, 1, 0, 0, 0, 0,          0));
    tbl.push_back(mk(1, 10,'hFFFFFFFF, 0, 0, 0,      0, 0, 1, 0, 1, 10,'hFFFFFFFF, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0, 0,      0, 0, 1, 0, 0, 0, 0,          0));
    // FIFO r5..r8 with idle ALU: drained in order, one per cycle
    tbl.push_back(mk(0, 0, 0,          1, 5, 'h105,  0, 0, 1, 0, 0, 0, 0,          1));
    tbl.push_back(mk(0, 0, 0,          1, 6, 'h106,  0, 0, 1, 0, 1, 5, 'h105,      1));
    tbl.push_back(mk(0, 0, 0,          1, 7, 'h107,  0, 0, 1, 0, 1, 6, 'h106,      1));
    tbl.push_back(mk(0, 0, 0,          1, 8, 'h108,  0, 0, 1, 0, 1, 7, 'h107,      1));
    tbl.push_back(mk(0, 0, 0,          0, 0, 0,      0, 0, 1, 0, 1, 8, 'h108,      0));
    // ALU busy: fill to 4, ready drops, forced pop when full still keeps ready low
    tbl.push_back(mk(1, 1, 'hA1,       1, 20,'h200,  0, 0, 1, 0, 1, 1, 'hA1,       1));
    tbl.push_back(mk(1, 2, 'hA2,       1, 21,'h201,  0, 0, 1, 0, 1, 2, 'hA2,       2));
    tbl.push_back(mk(1, 3, 'hA3,       1, 22,'h202,  0, 0, 1, 0, 1, 3, 'hA3,       3));
    tbl.push_back(mk(1, 4, 'hA4,       1, 23,'h203,  20,0, 1, 1, 1, 4, 'hA4,       4));
    tbl.push_back(mk(1, 5, 'hA5,       1, 24,'h204,  24,1, 0, 0, 1, 20,'h200,      3));
    tbl.push_back(mk(1, 5, 'hA5,       1, 24,'h204,  0, 0, 1, 0, 1, 5, 'hA5,       4));
    tbl.push_back(mk(0, 0, 0,          0, 0, 0,      24,0, 0, 1, 1, 21,'h201,      3));
    tbl.push_back(mk(0, 0, 0,          0, 0, 0,      0, 0, 1, 0, 1, 22,'h202,      2));
    tbl.push_back(mk(0, 0, 0,          0, 0, 0,      0, 0, 1, 0, 1, 23,'h203,      1));
    tbl.push_back(mk(0, 0, 0,          0, 0, 0,      0, 0, 1, 0, 1, 24,'h204,      0));
    tbl.push_back(mk(0, 0, 0,          0, 0, 0,      0, 0, 1, 0, 0, 0, 0,          0));
    // Starvation: r12 waits three ALU wins, then is forced through
    tbl.push_back(mk(1, 1, 'hB1,       1, 12,'hABCD, 12,0, 1, 0, 1, 1, 'hB1,       1));
    tbl.push_back(mk(1, 2, 'hB2,       0, 0, 0,      12,0, 1, 1, 1, 2, 'hB2,       1));
    tbl.push_back(mk(1, 3, 'hB3,       0, 0, 0,      0, 0, 1, 0, 1, 3, 'hB3,       1));
    tbl.push_back(mk(1, 4, 'hB4,       0, 0, 0,      0, 0, 1, 0, 1, 4, 'hB4,       1));
    tbl.push_back(mk(1, 5, 'hB5,       0, 0, 0,      12,1, 1, 1, 1, 12,'hABCD,     0));
    tbl.push_back(mk(1, 5, 'hB5,       0, 0, 0,      12,0, 1, 0, 1, 5, 'hB5,       0));
    tbl.push_back(mk(1, 6, 'hB6,       0, 0, 0,      0, 0, 1, 0, 1, 6, 'hB6,       0));
    tbl.push_back(mk(0, 0, 0,          0, 0, 0,      0, 0, 1, 0, 0, 0, 0,          0));
    // r9 queued, r0 accepted but dropped; hazard query
    tbl.push_back(mk(1, 7, 'hC7,       1, 9, 'h99,   9, 0, 1, 0, 1, 7, 'hC7,       1));
    tbl.push_back(mk(1, 8, 'hC8,       1, 0, 'hDEAD, 9, 0, 1, 1, 1, 8, 'hC8,       1));
    tbl.push_back(mk(0, 0, 0,          0, 0, 0,      0, 0, 1, 0, 1, 9, 'h99,       0));
    tbl.push_back(mk(0, 0, 0,          0, 0, 0,      9, 0, 1, 0, 0, 0, 0,          0));
    // Push+pop at count 2 across pointer wrap
    tbl.push_back(mk(1, 11,'hD1,       1, 13,'h130,  0, 0, 1, 0, 1, 11,'hD1,       1));
    tbl.push_back(mk(1, 12,'hD2,       1, 14,'h140,  0, 0, 1, 0, 1, 12,'hD2,       2));
    tbl.push_back(mk(0, 0, 0,          1, 15,'h150,  13,0, 1, 1, 1, 13,'h130,      2));
    tbl.push_back(mk(0, 0, 0,          1, 16,'h160,  15,0, 1, 1, 1, 14,'h140,      2));
    tbl.push_back(mk(0, 0, 0,          0, 0, 0,      0, 0, 1, 0, 1, 15,'h150,      1));
    tbl.push_back(mk(0, 0, 0,          0, 0, 0,      0, 0, 1, 0, 1, 16,'h160,      0));
    tbl.push_back(mk(0, 0, 0,          0, 0, 0,      0, 0, 1, 0, 0, 0, 0,          0));
    // Queue three entries ahead of the mid-operation reset
    tbl.push_back(mk(1, 1, 'hE1,       1, 17,'h170,  0, 0, 1, 0, 1, 1, 'hE1,       1));
    tbl.push_back(mk(1, 2, 'hE2,       1, 18,'h180,  0, 0, 1, 0, 1, 2, 'hE2,       2));
    tbl.push_back(mk(1, 3, 'hE3,       1, 19,'h190,  0, 0, 1, 0, 1, 3, 'hE3,       3));

    // Power-on reset
    idle_inputs();
    rst_i = 1'b1;
    #3;
    chk_reset_state();
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i]);
    end

    // Asynchronous reset mid-cycle with three queued entries
    idle_inputs();
    alu_valid_i = 1'b1;
    alu_addr_i  = 5'd30;
    rst_i       = 1'b1;
    #1;
    chk_reset_state();
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    chk_reset_state();
    idle_inputs();
    rst_i = 1'b0;

    // Discarded entries never reach the write port
    run_vec(mk(0, 0, 0,     0, 0, 0,  17, 0, 1, 0, 0, 0, 0,     0));
    run_vec(mk(0, 0, 0,     0, 0, 0,  18, 0, 1, 0, 0, 0, 0,     0));
    run_vec(mk(0, 0, 0,     0, 0, 0,  19, 0, 1, 0, 0, 0, 0,     0));
    run_vec(mk(1, 4, 'h44,  0, 0, 0,  0,  0, 1, 0, 1, 4, 'h44,  0));
    run_vec(mk(0, 0, 0,     0, 0, 0,  0,  0, 1, 0, 0, 0, 0,     0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_writeback_arbiter.md
Name: reg_writeback_arbiter

Overview:
- Write-side front end of the 32x32 register file. It merges two result sources into the file's single write port (RegWrite/RDaddr/RDdata):
  - single-cycle ALU results, which have priority;
  - multi-cycle memory/load results, buffered in a small FIFO.
- Guarantees one write per cycle, drops writes to r0, bounds FIFO starvation, and exposes a hazard check so decode can stall on reads of registers with pending load writes.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- FIFO_DEPTH, 4, memory-result FIFO entries (power of 2, >=2)
- STARVE_LIMIT, 3, consecutive cycles a non-empty FIFO may lose to the ALU before it is forced through

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- alu_valid_i  in  1  ALU result present this cycle
- alu_addr_i  in  ADDR_W  ALU destination register
- alu_data_i  in  DATA_W  ALU result
- alu_stall_o  out  1  ALU result not accepted this cycle; source holds it
- mem_valid_i  in  1  memory result offered
- mem_ready_o  out  1  FIFO can accept; transfer when valid&&ready
- mem_addr_i  in  ADDR_W  memory destination register
- mem_data_i  in  DATA_W  memory result
- chk_addr_i  in  ADDR_W  register address queried by decode
- chk_hazard_o  out  1  chk_addr_i matches a valid FIFO entry
- count_o  out  log2(FIFO_DEPTH)+1  FIFO occupancy
- RegWrite_o  out  1  register-file write enable
- RDaddr_o  out  ADDR_W  register-file write address
- RDdata_o  out  DATA_W  register-file write data

Behaviour:
- Reset (async, rst_i high):
  - RegWrite_o=0, RDaddr_o=0, RDdata_o=0.
  - FIFO empty, count_o=0, starvation counter=0.
  - mem_ready_o=0 and alu_stall_o=0 while rst_i is high.
  - Reset mid-operation discards all queued entries. No write is issued on the cycle after release.
- Write-port outputs are registered. A selection made in cycle N appears on RegWrite_o/RDaddr_o/RDdata_o in cycle N+1, for exactly one cycle.
- Selection each cycle:
  - force = FIFO non-empty && starve_cnt >= STARVE_LIMIT.
  - If force: pop the FIFO head; alu_stall_o = alu_valid_i. The ALU is not consumed and must hold its inputs.
  - Else if alu_valid_i: take the ALU result; alu_stall_o=0.
  - Else if FIFO non-empty: pop the head.
  - Else: next RegWrite_o=0, and RDaddr_o/RDdata_o hold their previous values.
- Starvation counter:
  - Increments when the FIFO is non-empty and the ALU wins.
  - Clears on any FIFO pop, and whenever the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- r0 suppression:
  - A selected ALU write with addr 0 yields RegWrite_o=0 next cycle and still counts as consumed.
  - A memory transfer with addr 0 is accepted (handshake completes) but not pushed. count_o is unchanged.
- FIFO:
  - mem_ready_o = !rst_i && (count < FIFO_DEPTH), from registered count only. No same-cycle pop credit: when full, ready=0 even if a pop occurs.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
  - Pops are strictly in arrival order.
- chk_hazard_o:
  - Combinational: 1 if chk_addr_i != 0 and any valid FIFO entry has that address.
  - The entry being pushed this cycle is not included.
  - An entry popped this cycle still counts until the edge.
- Ordering: the block does not resolve WAW hazards between ALU and FIFO entries. Decode must stall on chk_hazard_o before issuing an ALU op to a pending register.
- count_o: registered occupancy, 0..FIFO_DEPTH.

Test Plan:
- Reset, then ALU only: alu addr 3 / data 0x11, addr 0 / data 0x22, addr 10 / data 0xFFFFFFFF in consecutive cycles -> RegWrite_o pattern 1,0,1 one cycle later; RDaddr_o/RDdata_o = 3/0x11 and 10/0xFFFFFFFF on the writing cycles.
- Fill FIFO with mem writes to r5..r8 while the ALU is idle -> drained in order r5,r6,r7,r8, one per cycle. With the ALU held busy, mem_ready_o=0 once count_o=4.
- Continuous alu_valid_i with one FIFO entry (r12, 0xABCD) -> ALU wins 3 cycles. In cycle 4 alu_stall_o=1 and r12/0xABCD is written next cycle. The ALU resumes afterwards with no result lost or duplicated.
- Push mem r9 and r0 -> count_o=1. chk_addr_i=9 gives hazard=1; chk_addr_i=0 gives 0. After r9 drains, hazard=0.
- Simultaneous push and pop at count 2 -> count_o stays 2, order preserved across pointer wrap.
- Assert rst_i with 3 queued entries -> outputs 0 immediately, count_o=0, no write of discarded entries after release.
